bitmap_read_arbiter: RTL and testbench

//  Shares the single asynchronous-read bitmap memory address port between two

---
 rtl/bitmap_read_arbiter_pkg.sv | 18 +
 rtl/bitmap_read_arbiter_if.sv | 31 +++
 rtl/bitmap_read_arbiter.sv | 76 +++++++
 tb/tb_bitmap_read_arbiter.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/bitmap_read_arbiter_pkg.sv
// Shared types and sizing for the bitmap read arbiter.
// Defaults match a 4096-entry, 12-bit color bitmap memory.
// Arbiter state names the port that owns the next rvalid.
package bitmap_pkg;

  localparam int ABITS = 12;
  localparam int DBITS = 12;

  typedef logic [ABITS-1:0] bmap_addr_t;
  typedef logic [DBITS-1:0] color_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_G0   = 2'd1,
    S_G1   = 2'd2
  } arb_state_t;

endpackage

// File: rtl/bitmap_read_arbiter_if.sv
// Requester-side bundle for the bitmap read arbiter: two req/addr/gnt ports
// plus the shared registered read-data return with per-port valid flags.
// master = requesters (display + sprite engine), slave = arbiter.
interface bitmap_read_arbiter_if
  import bitmap_pkg::*;
#(
  parameter int Abits = ABITS,
  parameter int Dbits = DBITS
);

  logic             req0;
  logic [Abits-1:0] addr0;
  logic             gnt0;
  logic             rvalid0;
  logic             req1;
  logic [Abits-1:0] addr1;
  logic             gnt1;
  logic             rvalid1;
  logic [Dbits-1:0] rdata;

  modport master (
    output req0, addr0, req1, addr1,
    input  gnt0, gnt1, rvalid0, rvalid1, rdata
  );

  modport slave (
    input  req0, addr0, req1, addr1,
    output gnt0, gnt1, rvalid0, rvalid1, rdata
  );

endinterface

// File: rtl/bitmap_read_arbiter.sv
// Two-port arbiter for the async-read bitmap memory: port 0 priority, port 1 starvation-protected.
// Latency: grant is combinational; rdata/rvalid registered one cycle after the grant.
// Backpressure: a request held without grant stays pending (addr stable); dropping it withdraws it.
module bitmap_read_arbiter
  import bitmap_pkg::*;
#(
  parameter int Abits      = ABITS,
  parameter int Dbits      = DBITS,
  parameter int STARVE_LIM = 4
) (
  input  logic                 clk,
  input  logic                 reset_n,
  bitmap_read_arbiter_if.slave bus,
  output logic [Abits-1:0]     bitmap_addr,
  input  logic [Dbits-1:0]     color_value
);

  // A zero limit still needs a 1-bit counter; it simply sits at the limit.
  localparam int CW = (STARVE_LIM > 0) ? $clog2(STARVE_LIM + 1) : 1;
  localparam logic [CW-1:0] LIM = CW'(STARVE_LIM);

  arb_state_t       state_q, state_d;
  logic [CW-1:0]    starve_q, starve_d;
  logic [Abits-1:0] last_addr_q, last_addr_d;
  logic [Dbits-1:0] rdata_q, rdata_d;
  logic             force1, gnt0, gnt1;

  // Grant decision and memory address mux; grants are suppressed during reset.
  always_comb begin
    force1      = bus.req1 && (starve_q == LIM);
    gnt1        = reset_n && bus.req1 && (!bus.req0 || force1);
    gnt0        = reset_n && bus.req0 && !gnt1;
    bitmap_addr = gnt0 ? bus.addr0 : (gnt1 ? bus.addr1 : last_addr_q);
  end

  // Next-state: result owner, starvation count, held address and captured data.
  always_comb begin
    state_d     = S_IDLE;
    starve_d    = '0;
    last_addr_d = bitmap_addr;
    rdata_d     = rdata_q;
    if (gnt0) begin
      state_d = S_G0;
    end else if (gnt1) begin
      state_d = S_G1;
    end
    if (gnt0 || gnt1) begin
      rdata_d = color_value;
    end
    if (bus.req1 && !gnt1) begin
      starve_d = (starve_q == LIM) ? starve_q : starve_q + 1'b1;
    end
  end

  // State registers; reset drops any result still in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      starve_q    <= '0;
      last_addr_q <= '0;
      rdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      starve_q    <= starve_d;
      last_addr_q <= last_addr_d;
      rdata_q     <= rdata_d;
    end
  end

  assign bus.gnt0    = gnt0;
  assign bus.gnt1    = gnt1;
  assign bus.rvalid0 = (state_q == S_G0);
  assign bus.rvalid1 = (state_q == S_G1);
  assign bus.rdata   = rdata_q;

endmodule

// File: tb/tb_bitmap_read_arbiter.sv
// Self-checking bench for bitmap_read_arbiter: directed vector table, hand-written
// corner sequences (reset, withdraw, reset mid-transfer, zero starvation limit) and
// random traffic checked against a behavioural model of the arbitration rules.
module tb_bitmap_read_arbiter;

  localparam int LIM = 4;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [11:0] bitmap_addr, color_value;
  logic [11:0] bitmap_addr_z, color_value_z;

  int n_vec = 0;
  int n_bad = 0;

  bitmap_read_arbiter_if bus ();
  bitmap_read_arbiter_if bus_z ();

  bitmap_read_arbiter #(.Abits(12), .Dbits(12), .STARVE_LIM(LIM)) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus),
    .bitmap_addr(bitmap_addr), .color_value(color_value)
  );

  bitmap_read_arbiter #(.Abits(12), .Dbits(12), .STARVE_LIM(0)) dut_z (
    .clk(clk), .reset_n(reset_n), .bus(bus_z),
    .bitmap_addr(bitmap_addr_z), .color_value(color_value_z)
  );

  // Bitmap memory model: known contents mem[a] = a ^ 0xA5A, asynchronous read.
  assign color_value   = bitmap_addr ^ 12'hA5A;
  assign color_value_z = bitmap_addr_z ^ 12'hA5A;

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // ---------------- behavioural reference model ----------------
  int          m_denied;    // consecutive cycles port 1 has waited
  int          m_owner;     // 0 none, 1 port 0, 2 port 1
  logic [11:0] m_rdata, m_last;
  logic        lg0, lg1;

  task automatic model_reset();
    m_denied = 0; m_owner = 0; m_rdata = '0; m_last = '0; lg0 = 0; lg1 = 0;
  endtask

  // Check one cycle against the model, then advance the model across the edge.
  task automatic step(input string tag);
    logic eg0, eg1;
    logic [11:0] ea;
    eg1 = bus.req1 && (!bus.req0 || m_denied >= LIM);
    eg0 = bus.req0 && !eg1;
    ea  = eg0 ? bus.addr0 : (eg1 ? bus.addr1 : m_last);
    @(negedge clk);
    chk({tag, ".gnt0"}, 32'(bus.gnt0), 32'(eg0));
    chk({tag, ".gnt1"}, 32'(bus.gnt1), 32'(eg1));
    chk({tag, ".addr"}, 32'(bitmap_addr), 32'(ea));
    chk({tag, ".rvalid0"}, 32'(bus.rvalid0), 32'(m_owner == 1));
    chk({tag, ".rvalid1"}, 32'(bus.rvalid1), 32'(m_owner == 2));
    chk({tag, ".rdata"}, 32'(bus.rdata), 32'(m_rdata));
    @(posedge clk);
    m_owner  = eg0 ? 1 : (eg1 ? 2 : 0);
    if (eg0 || eg1) m_rdata = ea ^ 12'hA5A;
    m_last   = ea;
    m_denied = (bus.req1 && !eg1) ? m_denied + 1 : 0;
    lg0 = eg0; lg1 = eg1;
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    bus.req0 = 0; bus.req1 = 0; bus.addr0 = '0; bus.addr1 = '0;
    cyc(); cyc();
    reset_n = 1'b1;
    model_reset();
    cyc();
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic r0; logic [11:0] a0; logic r1; logic [11:0] a1;
    logic g0; logic g1; logic v0; logic v1; logic [11:0] rd; logic [11:0] ba;
  } vec_t;

  vec_t tbl[12];

  initial begin
    int waited;
    bit got;

    bus.req0 = 1; bus.req1 = 1; bus.addr0 = 12'h123; bus.addr1 = 12'h456;
    bus_z.req0 = 0; bus_z.req1 = 0; bus_z.addr0 = '0; bus_z.addr1 = '0;
    model_reset();

    tbl[0]  = '{1'b1, 12'h010, 1'b0, 12'h000, 1'b1, 1'b0, 1'b0, 1'b0, 12'h000, 12'h010};
    tbl[1]  = '{1'b0, 12'h000, 1'b0, 12'h000, 1'b0, 1'b0, 1'b1, 1'b0, 12'hA4A, 12'h010};
    tbl[2]  = '{1'b1, 12'h001, 1'b0, 12'h000, 1'b1, 1'b0, 1'b0, 1'b0, 12'hA4A, 12'h001};
    tbl[3]  = '{1'b0, 12'h000, 1'b1, 12'h002, 1'b0, 1'b1, 1'b1, 1'b0, 12'hA5B, 12'h002};
    tbl[4]  = '{1'b0, 12'h000, 1'b0, 12'h000, 1'b0, 1'b0, 1'b0, 1'b1, 12'hA58, 12'h002};
    tbl[5]  = '{1'b1, 12'h100, 1'b1, 12'h200, 1'b1, 1'b0, 1'b0, 1'b0, 12'hA58, 12'h100};
    tbl[6]  = '{1'b1, 12'h101, 1'b1, 12'h200, 1'b1, 1'b0, 1'b1, 1'b0, 12'hB5A, 12'h101};
    tbl[7]  = '{1'b1, 12'h102, 1'b1, 12'h200, 1'b1, 1'b0, 1'b1, 1'b0, 12'hB5B, 12'h102};
    tbl[8]  = '{1'b1, 12'h103, 1'b1, 12'h200, 1'b1, 1'b0, 1'b1, 1'b0, 12'hB58, 12'h103};
    tbl[9]  = '{1'b1, 12'h104, 1'b1, 12'h200, 1'b0, 1'b1, 1'b1, 1'b0, 12'hB59, 12'h200};
    tbl[10] = '{1'b1, 12'h104, 1'b1, 12'h201, 1'b1, 1'b0, 1'b0, 1'b1, 12'h85A, 12'h104};
    tbl[11] = '{1'b0, 12'h000, 1'b0, 12'h000, 1'b0, 1'b0, 1'b1, 1'b0, 12'hB5E, 12'h104};

    // Reset held with both requests up: no grants, outputs cleared.
    cyc();
    @(negedge clk);
    chk("rst.gnt0", 32'(bus.gnt0), 0);
    chk("rst.gnt1", 32'(bus.gnt1), 0);
    chk("rst.rvalid0", 32'(bus.rvalid0), 0);
    chk("rst.rvalid1", 32'(bus.rvalid1), 0);
    chk("rst.rdata", 32'(bus.rdata), 0);
    chk("rst.addr", 32'(bitmap_addr), 0);
    do_reset();

    for (int i = 0; i < 12; i++) begin
      bus.req0 = tbl[i].r0; bus.addr0 = tbl[i].a0;
      bus.req1 = tbl[i].r1; bus.addr1 = tbl[i].a1;
      @(negedge clk);
      chk($sformatf("tbl%0d.gnt0", i), 32'(bus.gnt0), 32'(tbl[i].g0));
      chk($sformatf("tbl%0d.gnt1", i), 32'(bus.gnt1), 32'(tbl[i].g1));
      chk($sformatf("tbl%0d.rvalid0", i), 32'(bus.rvalid0), 32'(tbl[i].v0));
      chk($sformatf("tbl%0d.rvalid1", i), 32'(bus.rvalid1), 32'(tbl[i].v1));
      chk($sformatf("tbl%0d.rdata", i), 32'(bus.rdata), 32'(tbl[i].rd));
      chk($sformatf("tbl%0d.addr", i), 32'(bitmap_addr), 32'(tbl[i].ba));
      cyc();
    end

    // Withdraw: port 1 waits two cycles then drops; the next conflict waits the full limit.
    do_reset();
    bus.req0 = 1; bus.addr0 = 12'h050; bus.req1 = 1; bus.addr1 = 12'h060;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("wd.gnt1", 32'(bus.gnt1), 0);
      chk("wd.rvalid1", 32'(bus.rvalid1), 0);
      cyc();
    end
    bus.req1 = 0;
    @(negedge clk);
    chk("wd.drop.gnt0", 32'(bus.gnt0), 1);
    chk("wd.drop.rvalid1", 32'(bus.rvalid1), 0);
    cyc();
    bus.req1 = 1; bus.addr1 = 12'h070;
    waited = 0; got = 0;
    for (int i = 0; i < 10 && !got; i++) begin
      @(negedge clk);
      chk("wd.rvalid1.quiet", 32'(bus.rvalid1), 0);
      if (bus.gnt1) got = 1; else waited++;
      cyc();
    end
    chk("wd.granted", 32'(got), 1);
    chk("wd.wait_cycles", 32'(waited), LIM);
    @(negedge clk);
    chk("wd.rvalid1.after", 32'(bus.rvalid1), 1);
    chk("wd.rdata.after", 32'(bus.rdata), 32'(12'h070 ^ 12'hA5A));
    cyc();

    // Reset lands while a port 1 grant is in flight: its rvalid must never appear.
    do_reset();
    bus.req1 = 1; bus.addr1 = 12'h333;
    @(negedge clk);
    chk("rmid.gnt1", 32'(bus.gnt1), 1);
    #1 reset_n = 1'b0;
    bus.req1 = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rmid.rvalid1", 32'(bus.rvalid1), 0);
    end
    reset_n = 1'b1;
    model_reset();
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("rmid.post.rvalid1", 32'(bus.rvalid1), 0);
      chk("rmid.post.addr", 32'(bitmap_addr), 0);
      chk("rmid.post.rdata", 32'(bus.rdata), 0);
    end
    cyc();

    // Random traffic against the model; pending addresses stay stable, withdrawals allowed.
    do_reset();
    for (int i = 0; i < 400; i++) begin
      if (bus.req0 && !lg0) begin
        if ($urandom_range(0, 7) == 0) bus.req0 = 0;
      end else begin
        bus.req0  = ($urandom_range(0, 2) != 0);
        bus.addr0 = 12'($urandom);
      end
      if (bus.req1 && !lg1) begin
        if ($urandom_range(0, 9) == 0) bus.req1 = 0;
      end else begin
        bus.req1  = ($urandom_range(0, 1) != 0);
        bus.addr1 = 12'($urandom);
      end
      step("rnd");
    end
    bus.req0 = 0; bus.req1 = 0;

    // Zero starvation limit: port 1 wins every conflict.
    do_reset();
    bus_z.req0 = 1; bus_z.addr0 = 12'h0AA; bus_z.req1 = 1; bus_z.addr1 = 12'h0BB;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("lim0.gnt1", 32'(bus_z.gnt1), 1);
      chk("lim0.gnt0", 32'(bus_z.gnt0), 0);
      chk("lim0.addr", 32'(bitmap_addr_z), 32'(12'h0BB));
      cyc();
    end
    @(negedge clk);
    chk("lim0.rvalid1", 32'(bus_z.rvalid1), 1);
    chk("lim0.rdata", 32'(bus_z.rdata), 32'(12'h0BB ^ 12'hA5A));
    bus_z.req0 = 0; bus_z.req1 = 0;
    cyc();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
